// File: rtl/flow_stat_acc.sv
// rtl/flow_stat_acc.sv - per-flow packet/byte statistics engine with update FIFO and host reads
module flow_stat_acc #(
  parameter int A_WIDTH     = 10,
  parameter int D_WIDTH     = 32,
  parameter int PKT_W       = 24,
  parameter int FIFO_AW     = 3,
  parameter int SAT         = 1,
  parameter int CLR_ON_READ = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] rx_flow_num_i,
  input  logic [15:0]        pkt_size_i,
  input  logic               pkt_size_en_i,
  input  logic               rd_stb_i,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  output logic               rd_busy_o,
  output logic [PKT_W-1:0]   rd_pkts_o,
  output logic [D_WIDTH-1:0] rd_bytes_o,
  output logic               rd_data_val_o,
  output logic [15:0]        drop_cnt_o,
  output logic               init_done_o
);

  localparam int DEPTH  = 1 << A_WIDTH;
  localparam int FDEPTH = 1 << FIFO_AW;
  localparam int EW     = PKT_W + D_WIDTH;
  localparam int FW     = A_WIDTH + 16;

  logic               init_done_q, init_done_d;
  logic [A_WIDTH-1:0] init_addr_q, init_addr_d;

  logic [FW-1:0]      fifo_mem [FDEPTH];
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic               fifo_empty, fifo_full, fifo_pop, fifo_push;
  logic [FW-1:0]      fifo_head;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic               rd_iss_q, rd_iss_d, rd_acc;
  logic [A_WIDTH-1:0] rd_flow_q, rd_flow_d;

  logic               iss_valid;
  logic [A_WIDTH-1:0] iss_flow;
  logic               ex_valid_q, ex_rd_q;
  logic [A_WIDTH-1:0] ex_flow_q;
  logic [15:0]        ex_size_q;

  logic [EW-1:0]      mem [DEPTH];
  logic [EW-1:0]      ram_rdata_q, ram_wdata;
  logic [A_WIDTH-1:0] ram_waddr;
  logic               ram_we;

  logic               wb_valid_q;
  logic [A_WIDTH-1:0] wb_flow_q;
  logic [EW-1:0]      wb_data_q;

  logic [EW-1:0]      ex_base, ex_wdata;
  logic [PKT_W-1:0]   ex_pkts, pkt_new;
  logic [D_WIDTH-1:0] ex_bytes, byte_new;
  logic [PKT_W:0]     pkt_sum;
  logic [D_WIDTH:0]   byte_sum;

  logic               rd_val_q;
  logic [PKT_W-1:0]   rd_pkts_q;
  logic [D_WIDTH-1:0] rd_bytes_q;

  assign rd_busy_o     = !init_done_q || rd_iss_q || (ex_valid_q && ex_rd_q);
  assign rd_acc        = rd_stb_i && !rd_busy_o;
  assign init_done_o   = init_done_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign rd_data_val_o = rd_val_q;
  assign rd_pkts_o     = rd_pkts_q;
  assign rd_bytes_o    = rd_bytes_q;

  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                      (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign fifo_head  = fifo_mem[rptr_q[FIFO_AW-1:0]];
  // A pending host read owns the issue slot; updates wait in the FIFO
  assign fifo_pop   = init_done_q && !rd_iss_q && !fifo_empty;
  assign fifo_push  = pkt_size_en_i && (!fifo_full || fifo_pop);

  assign iss_valid  = rd_iss_q || fifo_pop;
  assign iss_flow   = rd_iss_q ? rd_flow_q : fifo_head[FW-1:16];

  always_comb begin
    init_addr_d = init_addr_q;
    init_done_d = init_done_q;
    if (!init_done_q) begin
      init_addr_d = init_addr_q + 1'b1;
      if (init_addr_q == {A_WIDTH{1'b1}}) init_done_d = 1'b1;
    end
    wptr_d     = fifo_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d     = fifo_pop  ? rptr_q + 1'b1 : rptr_q;
    drop_cnt_d = drop_cnt_q;
    if (pkt_size_en_i && !fifo_push && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    rd_iss_d  = rd_acc;
    rd_flow_d = rd_acc ? rd_flow_num_i : rd_flow_q;
  end

  // Same-flow op written last cycle is not yet visible in the RAM read data
  assign ex_base  = (wb_valid_q && wb_flow_q == ex_flow_q) ? wb_data_q : ram_rdata_q;
  assign ex_pkts  = ex_base[EW-1:D_WIDTH];
  assign ex_bytes = ex_base[D_WIDTH-1:0];
  assign pkt_sum  = (PKT_W+1)'(ex_pkts) + (PKT_W+1)'(1);
  assign byte_sum = (D_WIDTH+1)'(ex_bytes) + (D_WIDTH+1)'(ex_size_q);

  always_comb begin
    pkt_new  = pkt_sum[PKT_W-1:0];
    byte_new = byte_sum[D_WIDTH-1:0];
    if (SAT != 0 && pkt_sum[PKT_W])    pkt_new  = '1;
    if (SAT != 0 && byte_sum[D_WIDTH]) byte_new = '1;
    if (!ex_rd_q)             ex_wdata = {pkt_new, byte_new};
    else if (CLR_ON_READ != 0) ex_wdata = '0;
    else                       ex_wdata = ex_base;
  end

  assign ram_we    = !init_done_q || ex_valid_q;
  assign ram_waddr = init_done_q ? ex_flow_q : init_addr_q;
  assign ram_wdata = init_done_q ? ex_wdata : '0;

  always_ff @(posedge clk_i) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata_q <= mem[iss_flow];
    if (fifo_push) fifo_mem[wptr_q[FIFO_AW-1:0]] <= {rx_flow_num_i, pkt_size_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_done_q <= 1'b0;
      init_addr_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      drop_cnt_q  <= '0;
      rd_iss_q    <= 1'b0;
      rd_flow_q   <= '0;
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= 1'b0;
      ex_flow_q   <= '0;
      ex_size_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_flow_q   <= '0;
      wb_data_q   <= '0;
      rd_val_q    <= 1'b0;
      rd_pkts_q   <= '0;
      rd_bytes_q  <= '0;
    end else begin
      init_done_q <= init_done_d;
      init_addr_q <= init_addr_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_iss_q    <= rd_iss_d;
      rd_flow_q   <= rd_flow_d;
      ex_valid_q  <= iss_valid;
      ex_rd_q     <= rd_iss_q;
      ex_flow_q   <= iss_flow;
      ex_size_q   <= rd_iss_q ? 16'd0 : fifo_head[15:0];
      wb_valid_q  <= ex_valid_q;
      wb_flow_q   <= ex_flow_q;
      wb_data_q   <= ex_wdata;
      rd_val_q    <= ex_valid_q && ex_rd_q;
      if (ex_valid_q && ex_rd_q) begin
        rd_pkts_q  <= ex_pkts;
        rd_bytes_q <= ex_bytes;
      end
    end
  end

endmodule

// File: tb/tb_flow_stat_acc.sv
// tb/tb_flow_stat_acc.sv - directed bench: saturating/keep and wrapping/clear-on-read instances
module tb_flow_stat_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rx_flow = '0;
  logic [15:0] pkt_size = '0;
  logic        en = 1'b0;
  logic        rd_stb = 1'b0;
  logic [3:0]  rd_flow = '0;

  logic        busy_s, val_s, idone_s, busy_w, val_w, idone_w;
  logic [3:0]  pk_s, pk_w;
  logic [15:0] by_s, by_w, drop_s, drop_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  flow_stat_acc #(.A_WIDTH(4), .D_WIDTH(16), .PKT_W(4), .FIFO_AW(3), .SAT(1), .CLR_ON_READ(0)) dut_s (
    .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(pkt_size), .pkt_size_en_i(en),
    .rd_stb_i(rd_stb), .rd_flow_num_i(rd_flow), .rd_busy_o(busy_s), .rd_pkts_o(pk_s),
    .rd_bytes_o(by_s), .rd_data_val_o(val_s), .drop_cnt_o(drop_s), .init_done_o(idone_s));

  flow_stat_acc #(.A_WIDTH(4), .D_WIDTH(16), .PKT_W(4), .FIFO_AW(3), .SAT(0), .CLR_ON_READ(1)) dut_w (
    .clk_i(clk), .rst_i(rst), .rx_flow_num_i(rx_flow), .pkt_size_i(pkt_size), .pkt_size_en_i(en),
    .rd_stb_i(rd_stb), .rd_flow_num_i(rd_flow), .rd_busy_o(busy_w), .rd_pkts_o(pk_w),
    .rd_bytes_o(by_w), .rd_data_val_o(val_w), .drop_cnt_o(drop_w), .init_done_o(idone_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input int flow, input int size);
    @(negedge clk);
    en = 1'b1;
    rx_flow = flow[3:0];
    pkt_size = size[15:0];
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      en = 1'b0;
      rd_stb = 1'b0;
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (!(idone_s && idone_w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_s", 32'(idone_s), 32'd1);
    chk("init_done_w", 32'(idone_w), 32'd1);
  endtask

  // Read with fixed-latency checks; optional same-cycle update and strobe while busy
  task automatic do_read(input string tag, input int flow, input int ps, input int bs,
                         input int pw, input int bw, input bit extra_stb, input bit with_upd,
                         input int upd_sz);
    @(negedge clk);
    rd_stb = 1'b1;
    rd_flow = flow[3:0];
    en = with_upd;
    rx_flow = flow[3:0];
    pkt_size = upd_sz[15:0];
    @(negedge clk);
    rd_stb = 1'b0;
    en = 1'b0;
    chk({tag, "_busy_t1"}, 32'(busy_s), 32'd1);
    chk({tag, "_val_t1"}, 32'(val_s), 32'd0);
    if (extra_stb) begin
      rd_stb = 1'b1;
      rd_flow = rd_flow + 4'd1;
    end
    @(negedge clk);
    rd_stb = 1'b0;
    chk({tag, "_busy_t2"}, 32'(busy_w), 32'd1);
    @(negedge clk);
    chk({tag, "_val_s"}, 32'(val_s), 32'd1);
    chk({tag, "_val_w"}, 32'(val_w), 32'd1);
    chk({tag, "_busy_t3"}, 32'(busy_s), 32'd0);
    chk({tag, "_pkts_s"}, 32'(pk_s), 32'(ps));
    chk({tag, "_bytes_s"}, 32'(by_s), 32'(bs));
    chk({tag, "_pkts_w"}, 32'(pk_w), 32'(pw));
    chk({tag, "_bytes_w"}, 32'(by_w), 32'(bw));
    @(negedge clk);
    chk({tag, "_val_t4"}, 32'(val_s), 32'd0);
    chk({tag, "_hold_s"}, 32'(by_s), 32'(bs));
    if (extra_stb) begin
      idle(2);
      chk({tag, "_ignored_stb"}, 32'({val_s, val_w}), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_s), 32'd1);
    chk("rst_val", 32'({val_s, val_w}), 32'd0);
    chk("rst_pkts", 32'({pk_s, pk_w}), 32'd0);
    chk("rst_bytes", {by_s, by_w}, 32'd0);
    chk("rst_drop", {drop_s, drop_w}, 32'd0);
    chk("rst_init_done", 32'({idone_s, idone_w}), 32'd0);
    rst = 1'b0;

    // T3: 10 updates while init holds the FIFO closed
    for (int i = 0; i < 10; i++) upd(3, 10);
    idle(1);
    chk("t3_drop_s", 32'(drop_s), 32'd2);
    chk("t3_drop_w", 32'(drop_w), 32'd2);
    chk("t3_still_init", 32'(idone_s), 32'd0);
    chk("t3_busy_init", 32'(busy_s), 32'd1);
    wait_init();
    idle(12);
    do_read("t3", 3, 8, 80, 8, 80, 1'b0, 1'b0, 0);

    // T1: untouched flow
    do_read("t1", 5, 0, 0, 0, 0, 1'b0, 1'b0, 0);

    // T2: back-to-back same-flow updates
    for (int i = 0; i < 4; i++) upd(4, 100);
    idle(6);
    do_read("t2", 4, 4, 400, 4, 400, 1'b0, 1'b0, 0);

    // T4: packet counter saturate vs wrap
    for (int i = 0; i < 17; i++) upd(1, 1);
    idle(6);
    do_read("t4", 1, 15, 17, 1, 17, 1'b0, 1'b0, 0);

    // Byte counter saturate vs wrap, then zero-length packet
    upd(6, 16'hFFFF);
    upd(6, 16'hFFFF);
    upd(6, 0);
    idle(6);
    do_read("bsat", 6, 3, 16'hFFFF, 3, 16'hFFFE, 1'b0, 1'b0, 0);

    // T5: clear-on-read, strobe while busy ignored, counting resumes from zero
    for (int i = 0; i < 3; i++) upd(2, 64);
    idle(6);
    do_read("t5a", 2, 3, 192, 3, 192, 1'b1, 1'b0, 0);
    do_read("t5b", 2, 3, 192, 0, 0, 1'b0, 1'b0, 0);
    upd(2, 5);
    idle(6);
    do_read("t5c", 2, 4, 197, 1, 5, 1'b0, 1'b0, 0);

    // Read issued right behind an update of the same flow
    upd(8, 7);
    do_read("fwd", 8, 1, 7, 1, 7, 1'b0, 1'b0, 0);

    // Same-cycle read and update: read sees the value before the update
    upd(7, 1);
    idle(6);
    do_read("simul", 7, 1, 1, 1, 1, 1'b0, 1'b1, 9);
    idle(6);
    do_read("simul2", 7, 2, 10, 1, 9, 1'b0, 1'b0, 0);

    // T6: reset mid-stream
    upd(9, 5);
    upd(9, 5);
    upd(9, 5);
    @(negedge clk);
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_pkts", 32'({pk_s, pk_w}), 32'd0);
    chk("t6_bytes", {by_s, by_w}, 32'd0);
    chk("t6_drop", {drop_s, drop_w}, 32'd0);
    chk("t6_init_done", 32'({idone_s, idone_w}), 32'd0);
    chk("t6_busy", 32'({busy_s, busy_w}), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    wait_init();
    idle(10);
    do_read("t6_f9", 9, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    do_read("t6_f3", 3, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    do_read("t6_f1", 1, 0, 0, 0, 0, 1'b0, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
